pipeline_hazard_ctrl: RTL and testbench

//  Drives the stall, flush and forward controls of the 5-stage pipeline, including i_CLR of decode_to_execute_reg.

---
 rtl/mips_pipe_pkg.sv | 13 +
 rtl/mdu_busy_tracker.sv | 40 ++++
 rtl/pipeline_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared constants for the MIPS pipeline control blocks.
// Writeback select encodings and forwarding mux selects.
package mips_pipe_pkg;

    localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
    localparam logic [1:0] MEMTOREG_LOAD = 2'b01;
    localparam logic [1:0] MEMTOREG_PC8  = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/mdu_busy_tracker.sv
// Busy countdown for the multi-cycle multiply/divide unit.
// A start (re)loads the latency; otherwise counts down to zero.
module mdu_busy_tracker #(
    parameter int LATENCY   = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    output logic busy_o
);

    localparam logic [CNT_WIDTH-1:0] LOAD = CNT_WIDTH'(LATENCY);
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Next count: reload on start, else decrement and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Count register, cleared asynchronously so a pending stall drops at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall, flush and forwarding control for the 5-stage pipeline.
// Hazard detection is combinational; MDU busy and stall count are registered.
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int RF_ADDR_WIDTH   = 5,
    parameter int MDU_LATENCY     = 4,
    parameter int MDU_CNT_WIDTH   = 3,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       i_CLK,
    input  logic                       i_RST,
    input  logic [RF_ADDR_WIDTH-1:0]   i_RsD,
    input  logic [RF_ADDR_WIDTH-1:0]   i_RtD,
    input  logic [RF_ADDR_WIDTH-1:0]   i_RsE,
    input  logic [RF_ADDR_WIDTH-1:0]   i_RtE,
    input  logic [RF_ADDR_WIDTH-1:0]   i_WriteRegE,
    input  logic [RF_ADDR_WIDTH-1:0]   i_WriteRegM,
    input  logic [RF_ADDR_WIDTH-1:0]   i_WriteRegW,
    input  logic                       i_RegWriteE,
    input  logic                       i_RegWriteM,
    input  logic                       i_RegWriteW,
    input  logic [1:0]                 i_MemtoRegE,
    input  logic [1:0]                 i_MemtoRegM,
    input  logic                       i_BranchD,
    input  logic                       i_JrD,
    input  logic                       i_PCSrcD,
    input  logic                       i_MduStartE,
    input  logic                       i_HiLoReadD,
    input  logic                       i_StallCntClr,
    output logic                       o_StallF,
    output logic                       o_StallD,
    output logic                       o_FlushD,
    output logic                       o_FlushE,
    output logic [1:0]                 o_ForwardAE,
    output logic [1:0]                 o_ForwardBE,
    output logic                       o_ForwardAD,
    output logic                       o_ForwardBD,
    output logic                       o_MduBusy,
    output logic [STALL_CNT_WIDTH-1:0] o_StallCnt
);

    localparam logic [STALL_CNT_WIDTH-1:0] SC_ONE = STALL_CNT_WIDTH'(1);

    // Register 0 is hardwired, so it never produces a hazard.
    function automatic logic hit(
        input logic [RF_ADDR_WIDTH-1:0] dst,
        input logic [RF_ADDR_WIDTH-1:0] src
    );
        return (dst != '0) && (dst == src);
    endfunction

    logic mdu_busy;
    logic lwstall;
    logic brstall;
    logic mdustall;
    logic stall;
    logic e_hit_d;
    logic m_hit_d;

    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_d;

    mdu_busy_tracker #(
        .LATENCY  (MDU_LATENCY),
        .CNT_WIDTH(MDU_CNT_WIDTH)
    ) u_mdu_busy (
        .clk_i  (i_CLK),
        .rst_ni (i_RST),
        .start_i(i_MduStartE),
        .busy_o (mdu_busy)
    );

    // ALU operand forwarding; the younger MEM result wins over WB.
    always_comb begin
        o_ForwardAE = FWD_RF;
        o_ForwardBE = FWD_RF;
        if (i_RegWriteM && hit(i_WriteRegM, i_RsE)) begin
            o_ForwardAE = FWD_MEM;
        end else if (i_RegWriteW && hit(i_WriteRegW, i_RsE)) begin
            o_ForwardAE = FWD_WB;
        end
        if (i_RegWriteM && hit(i_WriteRegM, i_RtE)) begin
            o_ForwardBE = FWD_MEM;
        end else if (i_RegWriteW && hit(i_WriteRegW, i_RtE)) begin
            o_ForwardBE = FWD_WB;
        end
    end

    assign o_ForwardAD = i_RegWriteM && hit(i_WriteRegM, i_RsD);
    assign o_ForwardBD = i_RegWriteM && hit(i_WriteRegM, i_RtD);

    // Stall sources: load-use, decode-stage compare operands, HI/LO not ready.
    always_comb begin
        lwstall = (i_MemtoRegE == MEMTOREG_LOAD) && i_RegWriteE &&
                  (hit(i_WriteRegE, i_RsD) || hit(i_WriteRegE, i_RtD));
        e_hit_d = hit(i_WriteRegE, i_RsD) ||
                  (i_BranchD && hit(i_WriteRegE, i_RtD));
        m_hit_d = hit(i_WriteRegM, i_RsD) ||
                  (i_BranchD && hit(i_WriteRegM, i_RtD));
        brstall = (i_BranchD || i_JrD) &&
                  ((i_RegWriteE && e_hit_d) ||
                   ((i_MemtoRegM == MEMTOREG_LOAD) && m_hit_d));
        mdustall = i_HiLoReadD && (mdu_busy || i_MduStartE);
        stall    = lwstall || brstall || mdustall;
    end

    assign o_StallF  = stall;
    assign o_StallD  = stall;
    assign o_FlushE  = stall;
    assign o_FlushD  = i_PCSrcD && !stall;
    assign o_MduBusy = mdu_busy;

    // Stall-cycle counter: clear wins, otherwise saturating increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (i_StallCntClr) begin
            stall_cnt_d = '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + SC_ONE;
        end
    end

    // Performance counter register.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl.
// Narrow stall counter so saturation is reachable quickly.
module tb_pipeline_hazard_ctrl;

    localparam int AW  = 5;
    localparam int SCW = 4;

    // {StallF,StallD,FlushE,FlushD,FwdAE,FwdBE,FwdAD,FwdBD,MduBusy}
    localparam logic [10:0] NONE   = 11'b000_0000_0000;
    localparam logic [10:0] STL    = 11'b111_0000_0000;
    localparam logic [10:0] FLD    = 11'b000_1000_0000;
    localparam logic [10:0] AE_MEM = 11'b000_0100_0000;
    localparam logic [10:0] AE_WB  = 11'b000_0010_0000;
    localparam logic [10:0] BE_MEM = 11'b000_0001_0000;
    localparam logic [10:0] BE_WB  = 11'b000_0000_1000;
    localparam logic [10:0] AD     = 11'b000_0000_0100;
    localparam logic [10:0] BD     = 11'b000_0000_0010;
    localparam logic [10:0] BSY    = 11'b000_0000_0001;

    typedef struct {
        string       nm;
        logic [10:0] v;
    } exp_t;

    exp_t sbq[$];
    int   cq[$];
    int   total = 0;
    int   bad   = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] RsD, RtD, RsE, RtE, WrE, WrM, WrW;
    logic RegWrE, RegWrM, RegWrW;
    logic [1:0] MtrE, MtrM;
    logic BranchD, JrD, PCSrcD, MduStartE, HiLoReadD, Clr;
    logic StallF, StallD, FlushD, FlushE, FwdAD, FwdBD, MduBusy;
    logic [1:0] FwdAE, FwdBE;
    logic [SCW-1:0] StallCnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .RF_ADDR_WIDTH  (AW),
        .MDU_LATENCY    (4),
        .MDU_CNT_WIDTH  (3),
        .STALL_CNT_WIDTH(SCW)
    ) dut (
        .i_CLK        (clk),
        .i_RST        (rst_n),
        .i_RsD        (RsD),
        .i_RtD        (RtD),
        .i_RsE        (RsE),
        .i_RtE        (RtE),
        .i_WriteRegE  (WrE),
        .i_WriteRegM  (WrM),
        .i_WriteRegW  (WrW),
        .i_RegWriteE  (RegWrE),
        .i_RegWriteM  (RegWrM),
        .i_RegWriteW  (RegWrW),
        .i_MemtoRegE  (MtrE),
        .i_MemtoRegM  (MtrM),
        .i_BranchD    (BranchD),
        .i_JrD        (JrD),
        .i_PCSrcD     (PCSrcD),
        .i_MduStartE  (MduStartE),
        .i_HiLoReadD  (HiLoReadD),
        .i_StallCntClr(Clr),
        .o_StallF     (StallF),
        .o_StallD     (StallD),
        .o_FlushD     (FlushD),
        .o_FlushE     (FlushE),
        .o_ForwardAE  (FwdAE),
        .o_ForwardBE  (FwdBE),
        .o_ForwardAD  (FwdAD),
        .o_ForwardBD  (FwdBD),
        .o_MduBusy    (MduBusy),
        .o_StallCnt   (StallCnt)
    );

    function automatic logic [10:0] obs();
        return {StallF, StallD, FlushE, FlushD, FwdAE, FwdBE,
                FwdAD, FwdBD, MduBusy};
    endfunction

    task automatic idle();
        RsD = '0; RtD = '0; RsE = '0; RtE = '0;
        WrE = '0; WrM = '0; WrW = '0;
        RegWrE = 0; RegWrM = 0; RegWrW = 0;
        MtrE = 2'b00; MtrM = 2'b00;
        BranchD = 0; JrD = 0; PCSrcD = 0;
        MduStartE = 0; HiLoReadD = 0; Clr = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        int   c;
        idle();
        rst_n = 1'b0;
        sbq.push_back('{"reset_outs", NONE});
        cq.push_back(0);
        @(negedge clk);
        e = sbq.pop_front();
        c = cq.pop_front();
        total++;
        if (obs() !== e.v) begin
            bad++;
            $display("FAIL %s got=%b want=%b", e.nm, obs(), e.v);
        end
        total++;
        if (StallCnt !== SCW'(c)) begin
            bad++;
            $display("FAIL reset_cnt got=%0d want=%0d", StallCnt, c);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_mdu();
        exp_t e;
        int   c;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 idle();
            case (k)
                0: begin
                    MduStartE = 1;
                    sbq.push_back('{"rmdu_start", NONE});
                end
                default: begin
                    HiLoReadD = 1;
                    sbq.push_back('{"rmdu_busy", STL | BSY});
                end
            endcase
            @(negedge clk);
            e = sbq.pop_front();
            total++;
            if (obs() !== e.v) begin
                bad++;
                $display("FAIL %s[%0d] got=%b want=%b", e.nm, k, obs(), e.v);
            end
        end
        #1 rst_n = 1'b0;
        sbq.push_back('{"rmdu_async", NONE});
        cq.push_back(0);
        #1;
        e = sbq.pop_front();
        c = cq.pop_front();
        total++;
        if (obs() !== e.v) begin
            bad++;
            $display("FAIL %s got=%b want=%b", e.nm, obs(), e.v);
        end
        total++;
        if (StallCnt !== SCW'(c)) begin
            bad++;
            $display("FAIL rmdu_cnt got=%0d want=%0d", StallCnt, c);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
    endtask

    task automatic test_forward();
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 idle();
            case (k)
                0: begin
                    RsE = 5; RegWrM = 1; WrM = 5; RegWrW = 1; WrW = 5;
                    sbq.push_back('{"fwd_mem", AE_MEM});
                end
                1: begin
                    RsE = 5; RegWrM = 1; WrM = 0; RegWrW = 1; WrW = 5;
                    sbq.push_back('{"fwd_wb", AE_WB});
                end
                2: begin
                    RsE = 0; RegWrM = 1; WrM = 5; RegWrW = 1; WrW = 5;
                    sbq.push_back('{"fwd_r0", NONE});
                end
                3: begin
                    RtE = 7; RsD = 7; RtD = 7;
                    RegWrM = 1; WrM = 7; RegWrW = 1; WrW = 7;
                    sbq.push_back('{"fwd_b_d", BE_MEM | AD | BD});
                end
                default: begin
                    RtE = 7; RsD = 7; RtD = 7;
                    RegWrM = 0; WrM = 7; RegWrW = 1; WrW = 7;
                    sbq.push_back('{"fwd_b_wb", BE_WB});
                end
            endcase
            @(negedge clk);
            e = sbq.pop_front();
            total++;
            if (obs() !== e.v) begin
                bad++;
                $display("FAIL %s got=%b want=%b", e.nm, obs(), e.v);
            end
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1 idle();
            case (k)
                0: begin
                    MtrE = 2'b01; RegWrE = 1; WrE = 8; RtD = 8;
                    sbq.push_back('{"lw_rt", STL});
                end
                1: sbq.push_back('{"lw_gone", NONE});
                2: begin
                    MtrE = 2'b01; RegWrE = 1; WrE = 0; RtD = 0;
                    sbq.push_back('{"lw_r0", NONE});
                end
                3: begin
                    MtrE = 2'b01; RegWrE = 1; WrE = 8; RsD = 8;
                    sbq.push_back('{"lw_rs", STL});
                end
                4: begin
                    MtrE = 2'b00; RegWrE = 1; WrE = 8; RsD = 8;
                    sbq.push_back('{"lw_alu", NONE});
                end
                default: begin
                    MtrE = 2'b01; RegWrE = 0; WrE = 8; RsD = 8;
                    sbq.push_back('{"lw_nowr", NONE});
                end
            endcase
            @(negedge clk);
            e = sbq.pop_front();
            total++;
            if (obs() !== e.v) begin
                bad++;
                $display("FAIL %s got=%b want=%b", e.nm, obs(), e.v);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1 idle();
            case (k)
                0: begin
                    BranchD = 1; PCSrcD = 1; RegWrE = 1; WrE = 3; RsD = 3;
                    sbq.push_back('{"br_e_stall", STL});
                end
                1: begin
                    BranchD = 1; PCSrcD = 1; RsD = 3;
                    sbq.push_back('{"br_flush", FLD});
                end
                2: begin
                    BranchD = 1; PCSrcD = 1; MtrM = 2'b01;
                    RegWrM = 1; WrM = 6; RtD = 6; RsD = 2;
                    sbq.push_back('{"br_m_load", STL | BD});
                end
                3: begin
                    JrD = 1; PCSrcD = 1; RsD = 4; RtD = 6;
                    RegWrE = 1; WrE = 6;
                    sbq.push_back('{"jr_rt_ign", FLD});
                end
                4: begin
                    JrD = 1; PCSrcD = 1; RsD = 4; MtrM = 2'b01;
                    RegWrM = 1; WrM = 4;
                    sbq.push_back('{"jr_m_load", STL | AD});
                end
                default: begin
                    BranchD = 1; RegWrE = 1; WrE = 0; RsD = 0;
                    sbq.push_back('{"br_r0", NONE});
                end
            endcase
            @(negedge clk);
            e = sbq.pop_front();
            total++;
            if (obs() !== e.v) begin
                bad++;
                $display("FAIL %s got=%b want=%b", e.nm, obs(), e.v);
            end
        end
    endtask

    task automatic test_mdu();
        exp_t e;
        for (int k = 0; k < 21; k++) begin
            @(posedge clk);
            #1 idle();
            HiLoReadD = (k <= 14);
            MduStartE = (k == 0) || (k == 7) || (k == 9) || (k == 15);
            if (k == 0 || k == 7)
                sbq.push_back('{"mdu_start", STL});
            else if ((k >= 1 && k <= 4) || (k >= 8 && k <= 13))
                sbq.push_back('{"mdu_hold", STL | BSY});
            else if (k == 5 || k == 14)
                sbq.push_back('{"mdu_release", NONE});
            else if (k >= 16 && k <= 19)
                sbq.push_back('{"mdu_busy_only", BSY});
            else
                sbq.push_back('{"mdu_idle", NONE});
            @(negedge clk);
            e = sbq.pop_front();
            total++;
            if (obs() !== e.v) begin
                bad++;
                $display("FAIL %s[%0d] got=%b want=%b", e.nm, k, obs(), e.v);
            end
        end
    endtask

    task automatic test_stallcnt();
        int c;
        int want;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1 idle();
            if (k >= 1 && k <= 22) begin
                MtrE = 2'b01; RegWrE = 1; WrE = 9; RsD = 9;
            end
            Clr = (k == 0) || (k == 21);
            if (k >= 1) begin
                if (k <= 21) want = (k - 1 > 15) ? 15 : k - 1;
                else want = k - 22;
                cq.push_back(want);
            end
            @(negedge clk);
            if (k >= 1) begin
                c = cq.pop_front();
                total++;
                if (StallCnt !== SCW'(c)) begin
                    bad++;
                    $display("FAIL stallcnt[%0d] got=%0d want=%0d",
                             k, StallCnt, c);
                end
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_reset_mid_mdu();
        test_forward();
        test_load_use();
        test_branch();
        test_mdu();
        test_stallcnt();
        if (sbq.size() != 0 || cq.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d want=0", sbq.size() + cq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
